// File: rtl/shift_reg_seq.sv
`default_nettype none
//==============================================================================
// Module   : shift_reg_seq
// Purpose  : Sequential shift/rotate register. Hold, load, clear and zero-
//            distance shifts finish on the accepting edge. Shifts/rotates of
//            distance k>0 execute one bit per clock over k further edges.
// Ports    : clock - rising-edge clock
//            reset - asynchronous, active-low reset
//            start - operation request (sampled only while idle)
//            f     - opcode (hold/load/shr/asr/shl/rotr/rotl/clear)
//            d     - load data
//            amt   - shift/rotate distance
//            q     - register contents
//            busy  - multi-cycle shift in progress
//            done  - one-cycle completion pulse
//            cout  - last bit shifted or rotated out
// Revision : 1.0 - initial release
//==============================================================================
module shift_reg_seq #(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       f,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             cout
);

    localparam logic [2:0]    c_OP_HOLD  = 3'b000;
    localparam logic [2:0]    c_OP_LOAD  = 3'b001;
    localparam logic [2:0]    c_OP_SHR   = 3'b010;
    localparam logic [2:0]    c_OP_ASR   = 3'b011;
    localparam logic [2:0]    c_OP_SHL   = 3'b100;
    localparam logic [2:0]    c_OP_ROTR  = 3'b101;
    localparam logic [2:0]    c_OP_ROTL  = 3'b110;
    localparam logic [2:0]    c_OP_CLEAR = 3'b111;
    localparam logic [AW-1:0] c_CNT_ONE  = AW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q,     w_q_nxt;
    logic [AW-1:0]    r_cnt,   w_cnt_nxt;
    logic [2:0]       r_op,    w_op_nxt;
    logic             r_cout,  w_cout_nxt;
    logic             r_done,  w_done_nxt;

    // Result of one 1-bit step of the latched operation.
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_cout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_op    <= c_OP_HOLD;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_cout  <= w_cout_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_step_q    = r_q;
        w_step_cout = r_cout;
        case (r_op)
            c_OP_SHR: begin
                w_step_q    = {1'b0, r_q[WIDTH-1:1]};
                w_step_cout = r_q[0];
            end
            c_OP_ASR: begin
                w_step_q    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_step_cout = r_q[0];
            end
            c_OP_SHL: begin
                w_step_q    = {r_q[WIDTH-2:0], 1'b0};
                w_step_cout = r_q[WIDTH-1];
            end
            c_OP_ROTR: begin
                w_step_q    = {r_q[0], r_q[WIDTH-1:1]};
                w_step_cout = r_q[0];
            end
            c_OP_ROTL: begin
                w_step_q    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_step_cout = r_q[WIDTH-1];
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_cout_nxt  = r_cout;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op_nxt = f;
                    case (f)
                        c_OP_HOLD: w_done_nxt = 1'b1;
                        c_OP_LOAD: begin
                            w_q_nxt    = d;
                            w_done_nxt = 1'b1;
                        end
                        c_OP_CLEAR: begin
                            w_q_nxt    = '0;
                            w_cout_nxt = 1'b0;
                            w_done_nxt = 1'b1;
                        end
                        default: begin
                            // Shift/rotate: zero distance completes at once,
                            // otherwise arm the step counter; q is untouched
                            // on the accepting edge.
                            if (amt == '0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt = ST_SHIFT;
                                w_cnt_nxt   = amt;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                w_q_nxt    = w_step_q;
                w_cout_nxt = w_step_cout;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign q    = r_q;
    assign busy = (r_state == ST_SHIFT);
    assign done = r_done;
    assign cout = r_cout;

endmodule
`default_nettype wire
